// File: rtl/lemmings_pkg.sv
// Shared constants and types for the lemming world environment model.
package lemmings_pkg;

  localparam int NCELLS_DEF      = 16;
  localparam int DIG_CYCLES_DEF  = 4;
  localparam int SPLAT_LIMIT_DEF = 20;

  localparam int LEM_POS_W = $clog2(NCELLS_DEF);
  // Wide enough for the saturating fall counter (0..31) and the 5-bit drop depth
  localparam int LEM_CNT_W = 5;

  typedef enum logic [0:0] {
    LVL_UPPER = 1'b0,
    LVL_FLOOR = 1'b1
  } level_t;

endpackage

// File: rtl/lemming_world_terrain.sv
// Terrain and wall storage for the upper level, with single-bit ground removal
// and reads at the lemming column and its two neighbours.
module lemming_world_terrain #(
  parameter int NCELLS = 16,
  parameter int POS_W  = $clog2(NCELLS)
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              load,
  input  logic [NCELLS-1:0] map_ground,
  input  logic [NCELLS-1:0] map_wall,
  input  logic              clr_en,
  input  logic [POS_W-1:0]  clr_idx,
  input  logic [POS_W-1:0]  rd_idx,
  output logic              ground_bit,
  output logic              wall_left,
  output logic              wall_right
);

  logic [NCELLS-1:0] terrain_q;
  logic [NCELLS-1:0] wall_q;

  // A reload replaces the whole map, so it wins over a dig completing that cycle
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      terrain_q <= '1;
      wall_q    <= '0;
    end else if (load) begin
      terrain_q <= map_ground;
      wall_q    <= map_wall;
    end else if (clr_en) begin
      terrain_q[clr_idx] <= 1'b0;
    end
  end

  assign ground_bit = terrain_q[rd_idx];
  assign wall_left  = (rd_idx != '0) ? wall_q[rd_idx - 1'b1] : 1'b0;
  assign wall_right = (int'(rd_idx) < NCELLS - 1) ? wall_q[rd_idx + 1'b1] : 1'b0;

endmodule

// File: rtl/lemming_world.sv
// Environment model for the walking/falling/digging lemming: consumes the
// lemming's state indications and produces its ground, bump and dig stimulus.
module lemming_world
  import lemmings_pkg::*;
#(
  parameter int NCELLS      = NCELLS_DEF,
  parameter int DIG_CYCLES  = DIG_CYCLES_DEF,
  parameter int SPLAT_LIMIT = SPLAT_LIMIT_DEF
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic                       load,
  input  logic [NCELLS-1:0]          map_ground,
  input  logic [NCELLS-1:0]          map_wall,
  input  logic [$clog2(NCELLS)-1:0]  start_pos,
  input  logic [4:0]                 drop_depth,
  input  logic                       dig_cmd,
  input  logic                       walk_left,
  input  logic                       walk_right,
  input  logic                       aaah,
  input  logic                       digging,
  output logic                       ground,
  output logic                       bump_left,
  output logic                       bump_right,
  output logic                       dig,
  output logic [$clog2(NCELLS)-1:0]  pos,
  output logic                       level,
  output logic                       splat
);

  localparam int POS_W = $clog2(NCELLS);
  localparam logic [POS_W-1:0]     LAST_POS = POS_W'(NCELLS - 1);
  localparam logic [LEM_CNT_W-1:0] DIG_LAST = LEM_CNT_W'(DIG_CYCLES - 1);

  level_t               level_q, level_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [POS_W-1:0]     start_clamped;
  logic [LEM_CNT_W-1:0] fall_cnt, dig_cnt, depth_q;
  logic [LEM_CNT_W:0]   fall_next, eff_depth;
  logic                 land;
  logic                 dig_done;
  logic                 terrain_bit, wall_left, wall_right;
  logic                 dig_q, splat_q;

  lemming_world_terrain #(
    .NCELLS (NCELLS),
    .POS_W  (POS_W)
  ) u_terrain (
    .clk        (clk),
    .areset     (areset),
    .load       (load),
    .map_ground (map_ground),
    .map_wall   (map_wall),
    .clr_en     (dig_done),
    .clr_idx    (pos_q),
    .rd_idx     (pos_q),
    .ground_bit (terrain_bit),
    .wall_left  (wall_left),
    .wall_right (wall_right)
  );

  // Only a non-power-of-two column count leaves start_pos codes to clamp
  generate
    if ((1 << POS_W) > NCELLS) begin : g_clamp
      assign start_clamped = (int'(start_pos) > NCELLS - 1) ? LAST_POS : start_pos;
    end else begin : g_noclamp
      assign start_clamped = start_pos;
    end
  endgenerate

  assign level      = (level_q == LVL_FLOOR);
  assign ground     = level ? 1'b1 : terrain_bit;
  assign bump_left  = (pos_q == '0) || (!level && wall_left);
  assign bump_right = (pos_q == LAST_POS) || (!level && wall_right);
  assign pos        = pos_q;
  assign dig        = dig_q;
  assign splat      = splat_q;

  assign fall_next = {1'b0, fall_cnt} + 1'b1;
  assign eff_depth = (depth_q == '0) ? (LEM_CNT_W+1)'(1) : {1'b0, depth_q};
  assign dig_done  = !load && digging && !level && (dig_cnt == DIG_LAST);

  always_comb begin
    level_d = level_q;
    land    = 1'b0;
    case (level_q)
      LVL_UPPER: begin
        if (aaah && (fall_next == eff_depth)) begin
          level_d = LVL_FLOOR;
          land    = 1'b1;
        end
      end
      LVL_FLOOR: level_d = LVL_FLOOR;
      default:   level_d = LVL_UPPER;
    endcase
    if (load) begin
      level_d = LVL_UPPER;
      land    = 1'b0;
    end
  end

  // Falling or digging pins the lemming; walking needs footing and a free side
  always_comb begin
    pos_d = pos_q;
    if (load) begin
      pos_d = start_clamped;
    end else if (!aaah && !digging) begin
      if (walk_left && ground && !bump_left) begin
        pos_d = pos_q - 1'b1;
      end else if (walk_right && ground && !bump_right) begin
        pos_d = pos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      level_q <= LVL_UPPER;
      pos_q   <= '0;
      dig_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      pos_q   <= pos_d;
      dig_q   <= dig_cmd;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      fall_cnt <= '0;
      dig_cnt  <= '0;
      depth_q  <= LEM_CNT_W'(1);
      splat_q  <= 1'b0;
    end else if (load) begin
      fall_cnt <= '0;
      dig_cnt  <= '0;
      depth_q  <= drop_depth;
      splat_q  <= 1'b0;
    end else begin
      if (!aaah) begin
        fall_cnt <= '0;
      end else if (!level) begin
        fall_cnt <= (fall_cnt == '1) ? fall_cnt : fall_next[LEM_CNT_W-1:0];
      end
      if (land && (int'(fall_next) > SPLAT_LIMIT)) begin
        splat_q <= 1'b1;
      end
      // Bedrock on the floor: the dig counter never runs there
      if (!digging || level) begin
        dig_cnt <= '0;
      end else if (dig_cnt == DIG_LAST) begin
        dig_cnt <= '0;
      end else begin
        dig_cnt <= dig_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lemming_world.sv
// Directed bench for lemming_world: the bench plays the lemming and checks the world's responses.
module tb_lemming_world;

  logic        clk = 1'b0;
  logic        areset;
  logic        load;
  logic [15:0] map_ground, map_wall;
  logic [3:0]  start_pos;
  logic [4:0]  drop_depth;
  logic        dig_cmd, walk_left, walk_right, aaah, digging;
  logic        ground, bump_left, bump_right, dig, level, splat;
  logic [3:0]  pos;

  int checks = 0;
  int fails  = 0;

  lemming_world dut (
    .clk        (clk),
    .areset     (areset),
    .load       (load),
    .map_ground (map_ground),
    .map_wall   (map_wall),
    .start_pos  (start_pos),
    .drop_depth (drop_depth),
    .dig_cmd    (dig_cmd),
    .walk_left  (walk_left),
    .walk_right (walk_right),
    .aaah       (aaah),
    .digging    (digging),
    .ground     (ground),
    .bump_left  (bump_left),
    .bump_right (bump_right),
    .dig        (dig),
    .pos        (pos),
    .level      (level),
    .splat      (splat)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] g, input logic [15:0] w,
                         input logic [3:0] sp, input logic [4:0] dd);
    map_ground = g; map_wall = w; start_pos = sp; drop_depth = dd;
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (ground !== 1'b1)     begin fails++; $display("[TB] FAIL rst_ground got %b exp 1", ground); end
    checks++; if (bump_left !== 1'b1)  begin fails++; $display("[TB] FAIL rst_bump_left got %b exp 1", bump_left); end
    checks++; if (bump_right !== 1'b0) begin fails++; $display("[TB] FAIL rst_bump_right got %b exp 0", bump_right); end
    checks++; if (dig !== 1'b0)        begin fails++; $display("[TB] FAIL rst_dig got %b exp 0", dig); end
    checks++; if (pos !== 4'd0)        begin fails++; $display("[TB] FAIL rst_pos got %0d exp 0", pos); end
    checks++; if (level !== 1'b0)      begin fails++; $display("[TB] FAIL rst_level got %b exp 0", level); end
    checks++; if (splat !== 1'b0)      begin fails++; $display("[TB] FAIL rst_splat got %b exp 0", splat); end
  endtask

  task automatic test_walk_edge;
    walk_left = 1'b1;
    checks++; if (bump_left !== 1'b1) begin fails++; $display("[TB] FAIL edge_bump_left got %b exp 1", bump_left); end
    step(1);
    checks++; if (pos !== 4'd0) begin fails++; $display("[TB] FAIL edge_hold got %0d exp 0", pos); end
    walk_left = 1'b0; walk_right = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      step(1);
      checks++; if (pos !== 4'(i)) begin fails++; $display("[TB] FAIL walk_right_pos got %0d exp %0d", pos, i); end
    end
    walk_right = 1'b0;
    do_load(16'hFFFF, 16'h0000, 4'd15, 5'd1);
    walk_right = 1'b1;
    checks++; if (bump_right !== 1'b1) begin fails++; $display("[TB] FAIL edge_bump_right got %b exp 1", bump_right); end
    step(2);
    checks++; if (pos !== 4'd15) begin fails++; $display("[TB] FAIL edge_right_hold got %0d exp 15", pos); end
    walk_right = 1'b0;
  endtask

  task automatic test_wall;
    do_load(16'hFFFF, 16'h0020, 4'd2, 5'd1);
    checks++; if (pos !== 4'd2) begin fails++; $display("[TB] FAIL wall_start got %0d exp 2", pos); end
    walk_right = 1'b1;
    step(2);
    checks++; if (pos !== 4'd4) begin fails++; $display("[TB] FAIL wall_reach got %0d exp 4", pos); end
    checks++; if (bump_right !== 1'b1) begin fails++; $display("[TB] FAIL wall_bump_right got %b exp 1", bump_right); end
    checks++; if (bump_left !== 1'b0) begin fails++; $display("[TB] FAIL wall_bump_left got %b exp 0", bump_left); end
    step(2);
    checks++; if (pos !== 4'd4) begin fails++; $display("[TB] FAIL wall_hold got %0d exp 4", pos); end
    walk_right = 1'b0;
  endtask

  task automatic test_fall;
    do_load(16'hFFF7, 16'h0000, 4'd2, 5'd5);
    walk_right = 1'b1;
    step(1);
    walk_right = 1'b0;
    checks++; if (pos !== 4'd3) begin fails++; $display("[TB] FAIL fall_pos got %0d exp 3", pos); end
    checks++; if (ground !== 1'b0) begin fails++; $display("[TB] FAIL fall_hole got %b exp 0", ground); end
    aaah = 1'b1;
    step(4);
    checks++; if (level !== 1'b0) begin fails++; $display("[TB] FAIL fall_early got %b exp 0", level); end
    step(1);
    checks++; if (level !== 1'b1) begin fails++; $display("[TB] FAIL fall_land got %b exp 1", level); end
    checks++; if (ground !== 1'b1) begin fails++; $display("[TB] FAIL fall_floor got %b exp 1", ground); end
    checks++; if (splat !== 1'b0) begin fails++; $display("[TB] FAIL fall_splat got %b exp 0", splat); end
    aaah = 1'b0;
    step(1);
  endtask

  task automatic test_splat;
    do_load(16'hFFF7, 16'h0000, 4'd3, 5'd21);
    aaah = 1'b1;
    step(20);
    checks++; if (level !== 1'b0) begin fails++; $display("[TB] FAIL splat_early got %b exp 0", level); end
    step(1);
    checks++; if (level !== 1'b1) begin fails++; $display("[TB] FAIL splat_land got %b exp 1", level); end
    checks++; if (splat !== 1'b1) begin fails++; $display("[TB] FAIL splat_set got %b exp 1", splat); end
    aaah = 1'b0;
    step(3);
    checks++; if (splat !== 1'b1) begin fails++; $display("[TB] FAIL splat_sticky got %b exp 1", splat); end
    do_load(16'hFFF7, 16'h0000, 4'd3, 5'd20);
    checks++; if (splat !== 1'b0) begin fails++; $display("[TB] FAIL splat_load_clr got %b exp 0", splat); end
    aaah = 1'b1;
    step(20);
    checks++; if (level !== 1'b1) begin fails++; $display("[TB] FAIL limit_land got %b exp 1", level); end
    checks++; if (splat !== 1'b0) begin fails++; $display("[TB] FAIL limit_splat got %b exp 0", splat); end
    aaah = 1'b0;
    do_load(16'hFFF7, 16'h0000, 4'd3, 5'd0);
    aaah = 1'b1;
    step(1);
    checks++; if (level !== 1'b1) begin fails++; $display("[TB] FAIL depth0_land got %b exp 1", level); end
    aaah = 1'b0;
  endtask

  task automatic test_dig;
    do_load(16'hFFFF, 16'h0000, 4'd7, 5'd1);
    dig_cmd = 1'b1;
    step(1);
    dig_cmd = 1'b0;
    checks++; if (dig !== 1'b1) begin fails++; $display("[TB] FAIL dig_delay got %b exp 1", dig); end
    step(1);
    checks++; if (dig !== 1'b0) begin fails++; $display("[TB] FAIL dig_drop got %b exp 0", dig); end
    digging = 1'b1; step(2);
    digging = 1'b0; step(1);
    digging = 1'b1; step(3);
    checks++; if (ground !== 1'b1) begin fails++; $display("[TB] FAIL dig_partial got %b exp 1", ground); end
    step(1);
    checks++; if (ground !== 1'b0) begin fails++; $display("[TB] FAIL dig_done got %b exp 0", ground); end
    checks++; if (pos !== 4'd7) begin fails++; $display("[TB] FAIL dig_pos_hold got %0d exp 7", pos); end
    digging = 1'b0;
    aaah = 1'b1; step(1); aaah = 1'b0;
    checks++; if (level !== 1'b1) begin fails++; $display("[TB] FAIL dig_fall got %b exp 1", level); end
    digging = 1'b1; step(6); digging = 1'b0;
    checks++; if (ground !== 1'b1) begin fails++; $display("[TB] FAIL bedrock got %b exp 1", ground); end
  endtask

  task automatic test_load_mid_fall;
    do_load(16'hFFF7, 16'h0000, 4'd3, 5'd10);
    aaah = 1'b1;
    step(3);
    do_load(16'hFFFF, 16'h0000, 4'd9, 5'd5);
    checks++; if (pos !== 4'd9) begin fails++; $display("[TB] FAIL midload_pos got %0d exp 9", pos); end
    checks++; if (level !== 1'b0) begin fails++; $display("[TB] FAIL midload_level got %b exp 0", level); end
    checks++; if (splat !== 1'b0) begin fails++; $display("[TB] FAIL midload_splat got %b exp 0", splat); end
    step(4);
    checks++; if (level !== 1'b0) begin fails++; $display("[TB] FAIL midload_cnt_clr got %b exp 0", level); end
    step(1);
    checks++; if (level !== 1'b1) begin fails++; $display("[TB] FAIL midload_land got %b exp 1", level); end
    aaah = 1'b0;
  endtask

  task automatic test_async_reset;
    do_load(16'hFFFF, 16'h0001, 4'd5, 5'd1);
    digging = 1'b1;
    step(2);
    #2 areset = 1'b1;
    #1;
    checks++; if (pos !== 4'd0) begin fails++; $display("[TB] FAIL async_pos got %0d exp 0", pos); end
    checks++; if (bump_right !== 1'b0) begin fails++; $display("[TB] FAIL async_walls got %b exp 0", bump_right); end
    areset = 1'b0;
    step(3);
    checks++; if (ground !== 1'b1) begin fails++; $display("[TB] FAIL async_dig_discard got %b exp 1", ground); end
    step(1);
    checks++; if (ground !== 1'b0) begin fails++; $display("[TB] FAIL async_dig_fresh got %b exp 0", ground); end
    digging = 1'b0;
  endtask

  initial begin
    areset = 1'b1; load = 1'b0;
    map_ground = '0; map_wall = '0; start_pos = '0; drop_depth = '0;
    dig_cmd = 1'b0; walk_left = 1'b0; walk_right = 1'b0; aaah = 1'b0; digging = 1'b0;
    #12;
    test_reset;
    areset = 1'b0;
    test_walk_edge;
    test_wall;
    test_fall;
    test_splat;
    test_dig;
    test_load_mid_fall;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
